// File: rtl/stage_realign_pkg.sv
// Shared constants and width helpers for the stage realign gearbox.
package stage_realign_pkg;

  localparam int BYTE_W = 8;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

  // Bits needed to hold any count from 0 up to max_count inclusive.
  function automatic int count_w(input int max_count);
    return (clog2(max_count + 1) < 1) ? 1 : clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/byte_shift_insert.sv
// Combinational barrel: shift the byte buffer down, then drop an input beat
// in at a byte offset. Bytes vacated by the shift are zero filled.
module byte_shift_insert
  import stage_realign_pkg::*;
#(
  parameter int IN_BYTES  = 7,
  parameter int BUF_BYTES = 23,
  parameter int OFF_W     = 5
) (
  input  logic [BUF_BYTES*BYTE_W-1:0] buf_in,
  input  logic [OFF_W-1:0]            shift_bytes,
  input  logic                        insert_en,
  input  logic [OFF_W-1:0]            insert_off,
  input  logic [IN_BYTES*BYTE_W-1:0]  insert_data,
  output logic [BUF_BYTES*BYTE_W-1:0] buf_out
);

  logic [BUF_BYTES*BYTE_W-1:0] shifted;

  assign shifted = buf_in >> {shift_bytes, 3'b000};

  // Each output byte compares the offset against the few constant positions
  // that could land an input byte on it, avoiding a variable part-select.
  generate
    for (genvar gi = 0; gi < BUF_BYTES; gi++) begin : g_byte
      logic [BYTE_W-1:0] byte_next;
      always_comb begin
        byte_next = shifted[gi*BYTE_W +: BYTE_W];
        for (int j = 0; j < IN_BYTES; j++) begin
          if (insert_en && (gi >= j) && (insert_off == OFF_W'(gi - j))) begin
            byte_next = insert_data[j*BYTE_W +: BYTE_W];
          end
        end
      end
      assign buf_out[gi*BYTE_W +: BYTE_W] = byte_next;
    end
  endgenerate

endmodule

// File: rtl/stage_realign_gearbox.sv
// Byte gearbox: IN_BYTES-wide beats in, OUT_BYTES-wide words out, with a
// flush that drains a zero-padded final partial word.
module stage_realign_gearbox
  import stage_realign_pkg::*;
#(
  parameter int IN_BYTES  = 7,
  parameter int OUT_BYTES = 16,
  localparam int BUF_BYTES = OUT_BYTES + IN_BYTES,
  localparam int CNT_W     = count_w(BUF_BYTES),
  localparam int OB_W      = count_w(OUT_BYTES)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [IN_BYTES*BYTE_W-1:0]  in_data_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic                        flush_i,
  output logic [OUT_BYTES*BYTE_W-1:0] out_data_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [OB_W-1:0]             out_bytes_o,
  output logic                        out_last_o
);

  logic [BUF_BYTES*BYTE_W-1:0] data_reg, data_next;
  logic [CNT_W-1:0]            count_reg, count_next;
  logic                        flush_pend_reg, flush_pend_next;

  logic             full;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] avail;
  logic [CNT_W-1:0] pop_amt;
  logic [CNT_W-1:0] insert_off;

  assign full  = count_reg >= CNT_W'(OUT_BYTES);
  assign avail = full ? CNT_W'(OUT_BYTES) : count_reg;

  assign in_ready_o  = (count_reg <= CNT_W'(BUF_BYTES - IN_BYTES)) && !flush_pend_reg;
  assign out_valid_o = full || (flush_pend_reg && (count_reg != '0));
  assign out_last_o  = out_valid_o && flush_pend_reg && (count_reg <= CNT_W'(OUT_BYTES));
  assign out_bytes_o = out_valid_o ? OB_W'(avail) : '0;
  assign out_data_o  = data_reg[OUT_BYTES*BYTE_W-1:0];

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  // Shift happens before insertion, so the beat lands right after the
  // bytes that survive this cycle's pop.
  assign pop_amt    = pop ? avail : '0;
  assign insert_off = count_reg - pop_amt;

  byte_shift_insert #(
    .IN_BYTES (IN_BYTES),
    .BUF_BYTES(BUF_BYTES),
    .OFF_W    (CNT_W)
  ) u_shift_insert (
    .buf_in     (data_reg),
    .shift_bytes(pop_amt),
    .insert_en  (push),
    .insert_off (insert_off),
    .insert_data(in_data_i),
    .buf_out    (data_next)
  );

  always_comb begin
    count_next      = insert_off + (push ? CNT_W'(IN_BYTES) : '0);
    flush_pend_next = flush_pend_reg;
    if (flush_pend_reg) begin
      if ((pop && out_last_o) || (count_reg == '0)) begin
        flush_pend_next = 1'b0;
      end
    end else if (flush_i) begin
      flush_pend_next = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_reg       <= '0;
      count_reg      <= '0;
      flush_pend_reg <= 1'b0;
    end else begin
      data_reg       <= data_next;
      count_reg      <= count_next;
      flush_pend_reg <= flush_pend_next;
    end
  end

endmodule

// File: tb/tb_stage_realign_gearbox.sv
// Directed bench for stage_realign_gearbox (IN_BYTES=7, OUT_BYTES=16).
module tb_stage_realign_gearbox;

  logic         clk_i;
  logic         rst_i;
  logic [55:0]  in_data_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic         flush_i;
  logic [127:0] out_data_o;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [4:0]   out_bytes_o;
  logic         out_last_o;

  int checks;
  int failures;

  stage_realign_gearbox #(.IN_BYTES(7), .OUT_BYTES(16)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .flush_i    (flush_i),
    .out_data_o (out_data_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_bytes_o(out_bytes_o),
    .out_last_o (out_last_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic         in_valid;
    logic [7:0]   base;
    logic         flush;
    logic         out_ready;
    logic         exp_in_ready;
    logic         exp_out_valid;
    logic [4:0]   exp_bytes;
    logic         exp_last;
    logic         chk_data;
    logic [127:0] exp_data;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  function automatic logic [55:0] beat(input logic [7:0] base);
    logic [55:0] d;
    for (int j = 0; j < 7; j++) d[j*8 +: 8] = base + 8'(j);
    return d;
  endfunction

  function automatic logic [127:0] word_seq(input logic [7:0] base);
    logic [127:0] w;
    for (int j = 0; j < 16; j++) w[j*8 +: 8] = base + 8'(j);
    return w;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 128'(out_valid_o), 128'(0));
    check({tag, "_out_data"},  out_data_o,        128'(0));
    check({tag, "_out_bytes"}, 128'(out_bytes_o), 128'(0));
    check({tag, "_out_last"},  128'(out_last_o),  128'(0));
    check({tag, "_in_ready"},  128'(in_ready_o),  128'(1));
  endtask

  function automatic vec_t mk(input logic iv, input logic [7:0] base, input logic fl,
                              input logic rdy, input logic eir, input logic eov,
                              input logic [4:0] enb, input logic elast,
                              input logic chk, input logic [127:0] edata);
    vec_t v;
    v.in_valid = iv; v.base = base; v.flush = fl; v.out_ready = rdy;
    v.exp_in_ready = eir; v.exp_out_valid = eov; v.exp_bytes = enb;
    v.exp_last = elast; v.chk_data = chk; v.exp_data = edata;
    return v;
  endfunction

  int beats;
  int words;
  int cyc;
  logic [127:0] exp_word;

  initial begin
    checks = 0;
    failures = 0;
    rst_i = 1'b1;
    in_data_i = '0;
    in_valid_i = 1'b0;
    flush_i = 1'b0;
    out_ready_i = 1'b0;

    // Three beats with ready high, then flush of the 5-byte residue.
    vecs[0]  = mk(1, 8'h00, 0, 1, 1, 0, 5'd0,  0, 0, '0);
    vecs[1]  = mk(1, 8'h07, 0, 1, 1, 0, 5'd0,  0, 0, '0);
    vecs[2]  = mk(1, 8'h0E, 0, 1, 1, 0, 5'd0,  0, 0, '0);
    vecs[3]  = mk(0, 8'h00, 0, 1, 0, 1, 5'd16, 0, 1, 128'h0F0E0D0C0B0A09080706050403020100);
    vecs[4]  = mk(0, 8'h00, 0, 1, 1, 0, 5'd0,  0, 1, 128'h00000000000000000000001413121110);
    vecs[5]  = mk(0, 8'h00, 1, 1, 1, 0, 5'd0,  0, 0, '0);
    vecs[6]  = mk(0, 8'h00, 0, 1, 0, 1, 5'd5,  1, 1, 128'h00000000000000000000001413121110);
    vecs[7]  = mk(0, 8'h00, 0, 1, 1, 0, 5'd0,  0, 1, '0);
    // Flush while empty: in_ready low for one cycle only, no word.
    vecs[8]  = mk(0, 8'h00, 1, 1, 1, 0, 5'd0,  0, 0, '0);
    vecs[9]  = mk(0, 8'h00, 0, 1, 0, 0, 5'd0,  0, 0, '0);
    vecs[10] = mk(0, 8'h00, 0, 1, 1, 0, 5'd0,  0, 0, '0);
    // Stall with continuous input: accepted at 0, 7, 14, blocked at 21.
    vecs[11] = mk(1, 8'h20, 0, 0, 1, 0, 5'd0,  0, 0, '0);
    vecs[12] = mk(1, 8'h27, 0, 0, 1, 0, 5'd0,  0, 0, '0);
    vecs[13] = mk(1, 8'h2E, 0, 0, 1, 0, 5'd0,  0, 0, '0);
    vecs[14] = mk(1, 8'h35, 0, 0, 0, 1, 5'd16, 0, 1, 128'h2F2E2D2C2B2A29282726252423222120);
    vecs[15] = mk(1, 8'h35, 0, 0, 0, 1, 5'd16, 0, 1, 128'h2F2E2D2C2B2A29282726252423222120);
    vecs[16] = mk(1, 8'h35, 0, 1, 0, 1, 5'd16, 0, 1, 128'h2F2E2D2C2B2A29282726252423222120);
    vecs[17] = mk(1, 8'h35, 0, 0, 1, 0, 5'd0,  0, 1, 128'h00000000000000000000003433323130);
    vecs[18] = mk(0, 8'h00, 1, 0, 1, 0, 5'd0,  0, 1, 128'h000000003B3A39383736353433323130);
    vecs[19] = mk(0, 8'h00, 0, 1, 0, 1, 5'd12, 1, 1, 128'h000000003B3A39383736353433323130);
    // Flush coincident with the push at count 14: 16-byte word then 5-byte last.
    vecs[20] = mk(1, 8'h40, 0, 0, 1, 0, 5'd0,  0, 1, '0);
    vecs[21] = mk(1, 8'h47, 0, 0, 1, 0, 5'd0,  0, 0, '0);
    vecs[22] = mk(1, 8'h4E, 1, 0, 1, 0, 5'd0,  0, 0, '0);
    vecs[23] = mk(0, 8'h00, 0, 0, 0, 1, 5'd16, 0, 1, 128'h4F4E4D4C4B4A49484746454443424140);
    vecs[24] = mk(0, 8'h00, 0, 1, 0, 1, 5'd16, 0, 1, 128'h4F4E4D4C4B4A49484746454443424140);
    vecs[25] = mk(0, 8'h00, 0, 1, 0, 1, 5'd5,  1, 1, 128'h00000000000000000000005453525150);
    vecs[26] = mk(0, 8'h00, 0, 1, 1, 0, 5'd0,  0, 1, '0);

    #1;
    check_reset_outputs("reset");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk_i);
      in_valid_i  = vecs[i].in_valid;
      in_data_i   = vecs[i].in_valid ? beat(vecs[i].base) : '0;
      flush_i     = vecs[i].flush;
      out_ready_i = vecs[i].out_ready;
      #1;
      check($sformatf("v%0d_in_ready", i),  128'(in_ready_o),  128'(vecs[i].exp_in_ready));
      check($sformatf("v%0d_out_valid", i), 128'(out_valid_o), 128'(vecs[i].exp_out_valid));
      check($sformatf("v%0d_out_bytes", i), 128'(out_bytes_o), 128'(vecs[i].exp_bytes));
      check($sformatf("v%0d_out_last", i),  128'(out_last_o),  128'(vecs[i].exp_last));
      if (vecs[i].chk_data) check($sformatf("v%0d_out_data", i), out_data_o, vecs[i].exp_data);
      $display("vec %0d: in_valid=%0b flush=%0b out_ready=%0b -> in_ready=%0b out_valid=%0b bytes=%0d last=%0b",
               i, in_valid_i, flush_i, out_ready_i, in_ready_o, out_valid_o, out_bytes_o, out_last_o);
    end

    // Streaming: 32 beats of bytes 0x00..0xDF with ready held high.
    beats = 0;
    words = 0;
    cyc = 0;
    while (!(beats == 32 && words == 14) && cyc < 400) begin
      @(negedge clk_i);
      in_valid_i  = (beats < 32);
      in_data_i   = (beats < 32) ? beat(8'(beats * 7)) : '0;
      flush_i     = 1'b0;
      out_ready_i = 1'b1;
      #1;
      if (out_valid_o) begin
        exp_word = word_seq(8'(words * 16));
        check($sformatf("stream_w%0d_data", words), out_data_o, exp_word);
        check($sformatf("stream_w%0d_bytes", words), 128'(out_bytes_o), 128'(16));
        $display("stream word %0d: bytes=%0d data=%h", words, out_bytes_o, out_data_o);
        words++;
      end
      if (in_valid_i && in_ready_o) beats++;
      cyc++;
    end
    check("stream_beats", 128'(beats), 128'(32));
    check("stream_words", 128'(words), 128'(14));
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    check("stream_drained_valid", 128'(out_valid_o), 128'(0));

    // Fill to 21 with the output stalled, then reset asynchronously.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      in_valid_i  = 1'b1;
      in_data_i   = beat(8'h80 + 8'(k * 7));
      out_ready_i = 1'b0;
    end
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    check("stall21_in_ready", 128'(in_ready_o), 128'(0));
    check("stall21_out_data", out_data_o, word_seq(8'h80));
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    $display("async reset: out_valid=%0b in_ready=%0b", out_valid_o, in_ready_o);
    @(negedge clk_i);
    rst_i = 1'b0;
    in_valid_i = 1'b1;
    in_data_i = beat(8'h60);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    check("post_reset_data", out_data_o, {72'b0, beat(8'h60)});
    check("post_reset_valid", 128'(out_valid_o), 128'(0));
    check("post_reset_in_ready", 128'(in_ready_o), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
